// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel output selector and its round-robin picker.
package mux_pkg;

  // Selection mode as presented on the top-level mode pin
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Largest channel count the selector is built for
  localparam int N_MAX = 16;

  // Increment a channel index and wrap from n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting channel at or above ptr, wrapping modulo N.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_ok
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] req_dbl;
  logic           found;

  // Lower half keeps only channels at or above ptr; upper half is the full
  // request set, so a search from bit 0 naturally wraps past N-1
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    req_dbl = {req, req & mask};
  end

  // Lowest set bit of the doubled vector, folded back into 0..N-1
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    grant_ok = |req;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && req_dbl[i]) begin
        found = 1'b1;
        grant = (i >= N) ? SEL_W'(i - N) : SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel WIDTH-bit selector with a one-entry registered output and
// valid/ready handshakes; fixed-select or round-robin channel choice.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  // A channel count outside 2..N_MAX builds a block that never grants
  localparam bit N_LEGAL = (N >= 2) && (N <= N_MAX);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_ok;
  logic             fix_ok;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] next_ptr;

  // Round-robin search; fixed mode never looks at its result
  rr_pick #(
    .N(N)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .grant   (rr_grant),
    .grant_ok(rr_ok)
  );

  // Fixed select: a sel value with no matching channel is never ok
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) begin
        fix_ok = in_valid[i];
      end
    end
  end

  // Mode mux, effective in the same cycle the mode pin changes
  always_comb begin
    if (mode_e'(mode) == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_ok;
    end else begin
      grant    = sel;
      grant_ok = fix_ok;
    end
    grant_ok = grant_ok & N_LEGAL;
  end

  // Ready goes to the granted channel only when the output register can
  // take a word; held low while reset is asserted
  always_comb begin
    load_en  = ~out_valid | out_ready;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en & grant_ok & ~reset & (grant == SEL_W'(i));
    end
    xfer = |in_ready;
  end

  // Pick the granted word and the pointer that follows it
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
    next_ptr = SEL_W'(wrap_inc(int'(grant), N));
  end

  // Output register and round-robin pointer; a consume without a new load
  // empties the register but leaves data and channel untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      if (mode_e'(mode) == MODE_RR) begin
        ptr <= next_ptr;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // At most one producer is offered the port in any cycle
  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

  // A stalled word stays put until the consumer takes it
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_chan)));

endmodule
